// File: rtl/exc_vector_fetch.sv
// Exception-vector sequencer: fetches the handler byte for a cause and writes PC/EPC.
// Optional cause register output is enabled by defining EXC_CAUSE_REG_EN.
module exc_vector_fetch #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned EPC_OFFSET = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mem_read_ctrl,
  output logic        mem_wr,
  output logic [31:0] pc_out,
  output logic        pc_wr,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic        busy,
  output logic        done
`ifdef EXC_CAUSE_REG_EN
  ,
  output logic [31:0] cause_out,
  output logic        cause_wr
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LOAD,
    DONE
  } state_t;

  localparam logic [2:0]  LAT = 3'(MEM_LAT);
  localparam logic [31:0] OFS = 32'(EPC_OFFSET);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [2:0]  mrc_d;
  logic [31:0] pc_out_d, epc_out_d;
  logic        pc_wr_d, epc_wr_d, busy_d, done_d;

  // Only the low byte of memory data is a vector.
  logic data_unused;
  assign data_unused = ^mem_data_in[31:8];

  assign mem_wr = 1'b0;

`ifdef EXC_CAUSE_REG_EN
  logic [31:0] cause_out_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    mrc_d     = mem_read_ctrl;
    pc_out_d  = pc_out;
    epc_out_d = epc_out;
    pc_wr_d   = 1'b0;
    epc_wr_d  = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
`ifdef EXC_CAUSE_REG_EN
    cause_out_d = cause_out;
`endif
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        mrc_d  = 3'b000;
        if (exc_req && exc_cause != 2'b00) begin
          state_d   = ADDR;
          cnt_d     = LAT;
          cause_d   = exc_cause;
          mrc_d     = {1'b0, exc_cause};
          epc_wr_d  = 1'b1;
          epc_out_d = pc_in - OFS;
          busy_d    = 1'b1;
`ifdef EXC_CAUSE_REG_EN
          cause_out_d = {30'b0, exc_cause} - 32'd1;
`endif
        end
      end
      ADDR: begin
        mrc_d = {1'b0, cause_q};
        if (cnt_q <= 3'd1) begin
          // Read data is valid on the edge that enters LOAD.
          state_d  = LOAD;
          cnt_d    = 3'd0;
          pc_wr_d  = 1'b1;
          pc_out_d = {24'b0, mem_data_in[7:0]};
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      LOAD: begin
        state_d = DONE;
        mrc_d   = 3'b000;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      cause_q       <= 2'b00;
      mem_read_ctrl <= 3'b000;
      pc_out        <= 32'd0;
      epc_out       <= 32'd0;
      pc_wr         <= 1'b0;
      epc_wr        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef EXC_CAUSE_REG_EN
      cause_out     <= 32'd0;
      cause_wr      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      mem_read_ctrl <= mrc_d;
      pc_out        <= pc_out_d;
      epc_out       <= epc_out_d;
      pc_wr         <= pc_wr_d;
      epc_wr        <= epc_wr_d;
      busy          <= busy_d;
      done          <= done_d;
`ifdef EXC_CAUSE_REG_EN
      cause_out     <= cause_out_d;
      cause_wr      <= epc_wr_d;
`endif
    end
  end

endmodule

// File: doc/exc_vector_fetch.md
# exc_vector_fetch

Exception-vector sequencer for the multicycle CPU. On an exception request it steers the memory-address select toward the vector byte for the given cause (253, 254 or 255), waits out the memory read latency, and captures the vector byte. It then writes the zero-extended handler address into PC and the faulting instruction address into EPC. It sits between the control unit and memory: its `mem_read_ctrl` output feeds the memory-address select, and it consumes the memory read data.

## Interface
- `MEM_LAT`, default 1: memory read latency in cycles (legal 1..7).
- `EPC_OFFSET`, default 4: value subtracted from `pc_in` to form EPC.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `exc_req` in 1: exception request, level-sampled in IDLE only.
- `exc_cause` in 2: 01 opcode, 10 overflow, 11 div-by-zero; 00 invalid.
- `pc_in` in 32: current PC (already incremented).
- `mem_data_in` in 32: memory read data; vector byte in bits [7:0].
- `mem_read_ctrl` out 3: memory-address select. 000 PC, 001 addr 253, 010 addr 254, 011 addr 255.
- `mem_wr` out 1: memory write enable, constant 0.
- `pc_out` out 32: handler address.
- `pc_wr` out 1: one-cycle PC write strobe.
- `epc_out` out 32: faulting address.
- `epc_wr` out 1: one-cycle EPC write strobe.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `cause_out` out 32 (`EXC_CAUSE_REG_EN` only): cause code.
- `cause_wr` out 1 (`EXC_CAUSE_REG_EN` only): cause write strobe.

## Operation
- States: IDLE, ADDR, LOAD, DONE.
- IDLE:
  - `exc_req=1` with `exc_cause!=00`: latch the cause and `pc_in`, go to ADDR.
  - `exc_cause=00` is ignored; the block stays in IDLE.
- ADDR:
  - `mem_read_ctrl` = {1'b0, latched cause}.
  - Wait counter loads `MEM_LAT` on entry and decrements each cycle; go to LOAD when it reaches 1.
  - `epc_wr=1` for the first ADDR cycle only, with `epc_out = latched pc - EPC_OFFSET`. Arithmetic is modulo 2^32, so PC 0 gives 0xFFFFFFFC.
- LOAD:
  - `mem_read_ctrl` is held.
  - `pc_out = {24'b0, mem_data_in[7:0]}` is registered, and `pc_wr=1` for this cycle.
- DONE: `done=1`, `mem_read_ctrl` returns to 000; go to IDLE.
- `busy=1` in ADDR, LOAD and DONE.
- `exc_req` is ignored while busy. There is no queueing: a request is taken only in IDLE, so a request held through DONE is accepted in the following IDLE cycle.
- `mem_wr` is 0 in every state.
- Reset in any state: go to IDLE, clear the counter and latches.
- Reset values of all outputs: `mem_read_ctrl=000`, `pc_out=0`, `epc_out=0`, all strobes 0, `busy=0`, `done=0`, `cause_out=0`.

## Timing
- All outputs are registered.
- Request sampled at edge T; state is ADDR from T+1.
- `epc_wr` at T+1.
- ADDR occupies T+1 .. T+MEM_LAT.
- LOAD at T+MEM_LAT+1: samples `mem_data_in`, `pc_wr` asserted.
- `done` at T+MEM_LAT+2.
- Earliest next acceptance at edge T+MEM_LAT+3.
- Total latency from request to `done` = MEM_LAT+2 cycles (3 with the default).
- `pc_out` and `epc_out` hold their last written value until the next strobe.

## Configuration
- `EXC_CAUSE_REG_EN` defined:
  - Adds `cause_out` and `cause_wr`.
  - `cause_wr` pulses with `epc_wr`, with `cause_out = {30'b0, latched cause} - 1`: 0 opcode, 1 overflow, 2 div-by-zero.
- Undefined: the ports are absent and there is no cause logic; all other behaviour is identical.

## Test plan
- Overflow (`exc_cause=10`, `pc_in=0x104`), `MEM_LAT=1`, memory returns 0x0000003C:
  - `epc_wr` at T+1 with `epc_out=0x100`.
  - `mem_read_ctrl=010` at T+1..T+2.
  - `pc_wr` at T+2 with `pc_out=0x3C`.
  - `done` at T+3.
- Div-by-zero (`exc_cause=11`), `MEM_LAT=3`, data 0xFFFFFFA0: `mem_read_ctrl=011` for T+1..T+4, `pc_out=0x000000A0` at T+4, `done` at T+5.
- `exc_req=1` with `exc_cause=00` held 5 cycles: `busy` stays 0, no strobes.
- Second `exc_req` during ADDR or LOAD: ignored; exactly one `pc_wr` and one `done`.
- `reset` asserted in LOAD: next cycle all outputs are at reset values, `mem_read_ctrl=000`, no `done`.
- With `EXC_CAUSE_REG_EN`, opcode exception (`exc_cause=01`): `cause_wr` at T+1 with `cause_out=0`.
